// File: rtl/softmax_row_scheduler.sv
// Streams a job of int8 score rows from the score buffer through the softmax unit into the
// probability buffer. The quantization config is latched once per job.
module softmax_row_scheduler #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  cfg_num_rows,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [15:0]       cfg_in_scale,
  input  logic [15:0]       cfg_out_scale,
  input  logic [5:0]        cfg_shift,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              sm_in_valid,
  input  logic              sm_in_ready,
  output logic [DATA_W-1:0] sm_in_data,
  output logic [15:0]       sm_in_scale,
  output logic [15:0]       sm_out_scale,
  output logic [5:0]        sm_shift,
  input  logic              sm_out_valid,
  output logic              sm_out_ready,
  input  logic [DATA_W-1:0] sm_out_data,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ROW_W:0] CNT_ONE = 1;

  state_t state, state_next;

  logic [ROW_W:0]      num_rows_q;
  logic [ROW_W:0]      rd_cnt;
  logic [ROW_W:0]      wr_cnt;
  logic [ADDR_W-1:0]   rd_base_q;
  logic [ADDR_W-1:0]   wr_base_q;
  logic                rd_pending;

  logic [DATA_W-1:0]   fifo_mem [2];
  logic                fifo_wr_ptr;
  logic                fifo_rd_ptr;
  logic [1:0]          fifo_count;
  logic                fifo_push;
  logic                fifo_pop;
  logic [1:0]          credit_used;
  logic                start_ok;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (cfg_num_rows == '0) ? S_DONE : S_RUN;
      S_RUN:  if (wr_cnt == num_rows_q) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  assign start_ok = (state == S_IDLE) && start;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // ---------------------------------------------------------------- job config
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows_q   <= '0;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      sm_in_scale  <= '0;
      sm_out_scale <= '0;
      sm_shift     <= '0;
    end else if (start_ok) begin
      num_rows_q   <= {1'b0, cfg_num_rows};
      rd_base_q    <= cfg_rd_base;
      wr_base_q    <= cfg_wr_base;
      sm_in_scale  <= cfg_in_scale;
      sm_out_scale <= cfg_out_scale;
      sm_shift     <= cfg_shift;
    end
  end

  // ---------------------------------------------------------------- read side
  assign fifo_push = rd_pending;
  assign fifo_pop  = (fifo_count != 2'd0) && sm_in_ready;

  // Slots in use counted net of this cycle's pop, so a drained head frees its slot
  // immediately and a row can be issued every cycle.
  assign credit_used = {1'b0, rd_pending} + fifo_count - {1'b0, fifo_pop};

  assign rd_en   = (state == S_RUN) && (rd_cnt < num_rows_q) && (credit_used < 2'd2);
  assign rd_addr = rd_base_q + ADDR_W'(rd_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      if (start_ok)   rd_cnt <= '0;
      else if (rd_en) rd_cnt <= rd_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------- 2-entry skid FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two storage words are reset too; sm_in_data is a port and must read 0 out of reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_mem[fifo_wr_ptr] <= rd_data;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (fifo_pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign sm_in_valid = (fifo_count != 2'd0);
  assign sm_in_data  = fifo_mem[fifo_rd_ptr];

  // ---------------------------------------------------------------- write side
  // Ready is gated by RUN so nothing is drained while idle or in reset.
  assign sm_out_ready = wr_ready && (state == S_RUN);
  assign wr_en        = sm_out_valid && sm_out_ready;
  assign wr_data      = sm_out_data;
  assign wr_addr      = wr_base_q + ADDR_W'(wr_cnt);

  always_ff @(posedge clk) begin
    if (rst)            wr_cnt <= '0;
    else if (start_ok)  wr_cnt <= '0;
    else if (wr_en)     wr_cnt <= wr_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler: score SRAM model, fixed-latency softmax stand-in
// (output row = bitwise inverse of input row) and a write log checked against expected rows.
`timescale 1ns/1ps
module tb_softmax_row_scheduler;

  localparam int DATA_W   = 256;
  localparam int ADDR_W   = 10;
  localparam int ROW_W    = 8;
  localparam int SM_DELAY = 3;            // model pipeline depth
  localparam int SM_LAT   = SM_DELAY + 1; // handshake cycle to output-valid cycle

  logic              clk, rst, start;
  logic [ROW_W-1:0]  cfg_num_rows;
  logic [ADDR_W-1:0] cfg_rd_base, cfg_wr_base;
  logic [15:0]       cfg_in_scale, cfg_out_scale;
  logic [5:0]        cfg_shift;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              sm_in_valid, sm_in_ready;
  logic [DATA_W-1:0] sm_in_data;
  logic [15:0]       sm_in_scale, sm_out_scale;
  logic [5:0]        sm_shift;
  logic              sm_out_valid, sm_out_ready;
  logic [DATA_W-1:0] sm_out_data;
  logic              wr_ready, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  softmax_row_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_rows(cfg_num_rows), .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
    .cfg_in_scale(cfg_in_scale), .cfg_out_scale(cfg_out_scale), .cfg_shift(cfg_shift),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sm_in_valid(sm_in_valid), .sm_in_ready(sm_in_ready), .sm_in_data(sm_in_data),
    .sm_in_scale(sm_in_scale), .sm_out_scale(sm_out_scale), .sm_shift(sm_shift),
    .sm_out_valid(sm_out_valid), .sm_out_ready(sm_out_ready), .sm_out_data(sm_out_data),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DATA_W-1:0] score_word(input logic [ADDR_W-1:0] a);
    logic [31:0] lane;
    lane = {a, 22'h15A5A ^ {12'd0, a}};
    return {8{lane}};
  endfunction

  // Score SRAM: data valid exactly one cycle after rd_en, zero otherwise.
  always @(posedge clk) rd_data <= rd_en ? score_word(rd_addr) : '0;

  // Softmax stand-in: in-order pipeline, output = ~input, honours sm_out_ready.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } sm_item_t;
  sm_item_t sm_q[$];
  int sm_cyc = 0;

  always @(posedge clk) begin
    sm_cyc++;
    if (rst) begin
      sm_q.delete();
      sm_out_valid <= 1'b0;
      sm_out_data  <= '0;
    end else begin
      if (sm_out_valid && sm_out_ready) void'(sm_q.pop_front());
      if (sm_in_valid && sm_in_ready) sm_q.push_back('{~sm_in_data, sm_cyc + SM_DELAY});
      if (sm_q.size() > 0 && sm_q[0].due <= sm_cyc) begin
        sm_out_valid <= 1'b1;
        sm_out_data  <= sm_q[0].data;
      end else begin
        sm_out_valid <= 1'b0;
        sm_out_data  <= '0;
      end
    end
  end

  // Random sm_in_ready when enabled, otherwise held high.
  logic rand_in = 1'b0;
  initial begin
    sm_in_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      sm_in_ready = rand_in ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Mid-cycle monitor.
  logic [ADDR_W-1:0] rd_log[$];
  int                rd_cyc_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  int done_cnt = 0, stall_viol = 0, wr_viol = 0, neg_cyc = 0, first_in_cyc = -1;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    neg_cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        rd_log.push_back(rd_addr);
        rd_cyc_log.push_back(neg_cyc);
      end
      if (wr_en) begin
        wr_addr_log.push_back(wr_addr);
        wr_data_log.push_back(wr_data);
      end
      if (wr_en && !wr_ready) wr_viol++;
      if (done) done_cnt++;
      if (sm_in_valid && first_in_cyc < 0) first_in_cyc = neg_cyc;
      if (prev_stall && (!sm_in_valid || sm_in_data !== prev_data)) stall_viol++;
      prev_stall = sm_in_valid && !sm_in_ready;
      prev_data  = sm_in_data;
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); rd_cyc_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    done_cnt = 0; stall_viol = 0; wr_viol = 0; first_in_cyc = -1;
  endtask

  task automatic start_job(input int n, input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb,
                           input logic [15:0] is, input logic [15:0] os, input logic [5:0] sh);
    cfg_num_rows = ROW_W'(n); cfg_rd_base = rb; cfg_wr_base = wb;
    cfg_in_scale = is; cfg_out_scale = os; cfg_shift = sh;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cfg_num_rows  = 8'($urandom); cfg_rd_base = 10'($urandom); cfg_wr_base = 10'($urandom);
    cfg_in_scale  = 16'($urandom); cfg_out_scale = 16'($urandom); cfg_shift = 6'($urandom);
  endtask

  // Returns in the DONE cycle (or when the budget runs out).
  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_rows(input string tag, input int n,
                            input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
    logic [ADDR_W-1:0] ra, wa;
    check({tag, "_rd_count"}, rd_log.size(), n);
    check({tag, "_wr_count"}, wr_data_log.size(), n);
    for (int i = 0; i < n; i++) begin
      ra = rb + ADDR_W'(i);
      wa = wb + ADDR_W'(i);
      check($sformatf("%s_rd_addr%0d", tag, i), (i < rd_log.size()) ? rd_log[i] : '1, ra);
      check($sformatf("%s_wr_addr%0d", tag, i), (i < wr_addr_log.size()) ? wr_addr_log[i] : '1, wa);
      check($sformatf("%s_wr_data%0d", tag, i), (i < wr_data_log.size()) ? wr_data_log[i] : '0,
            ~score_word(ra));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cyc;

  initial begin
    // T1: reset, start held during reset is ignored
    rst = 1'b1; start = 1'b1; wr_ready = 1'b1;
    cfg_num_rows = 8'd5; cfg_rd_base = 10'h55; cfg_wr_base = 10'h66;
    cfg_in_scale = 16'hAAAA; cfg_out_scale = 16'hBBBB; cfg_shift = 6'h2A;
    tick(2);
    check("t1_busy", busy, 1'b0);
    check("t1_done", done, 1'b0);
    check("t1_rd_en", rd_en, 1'b0);
    check("t1_rd_addr", rd_addr, '0);
    check("t1_sm_in_valid", sm_in_valid, 1'b0);
    check("t1_sm_in_data", sm_in_data, '0);
    check("t1_sm_in_scale", sm_in_scale, '0);
    check("t1_sm_out_scale", sm_out_scale, '0);
    check("t1_sm_shift", sm_shift, '0);
    check("t1_sm_out_ready", sm_out_ready, 1'b0);
    check("t1_wr_en", wr_en, 1'b0);
    check("t1_wr_addr", wr_addr, '0);
    check("t1_wr_data", wr_data, '0);
    rst = 1'b0; start = 1'b0;
    clear_logs();
    tick(3);
    check("t1_idle_after_rst", busy, 1'b0);
    check("t1_no_reads", rd_log.size(), 0);

    // T2: single row, config latched and pins ignored afterwards
    start_job(1, 10'h010, 10'h080, 16'h1234, 16'h5678, 6'h15);
    check("t2_busy", busy, 1'b1);
    check("t2_in_scale", sm_in_scale, 16'h1234);
    check("t2_out_scale", sm_out_scale, 16'h5678);
    check("t2_shift", sm_shift, 6'h15);
    wait_done("t2", 100, cyc);
    check("t2_busy_in_done", busy, 1'b1);
    tick(1);
    check("t2_done_pulse_len", done, 1'b0);
    check("t2_busy_drop", busy, 1'b0);
    check("t2_done_count", done_cnt, 1);
    check("t2_scale_held", sm_in_scale, 16'h1234);
    check_rows("t2", 1, 10'h010, 10'h080);

    // T3: 32 rows streaming with all ready
    clear_logs();
    start_job(32, 10'h010, 10'h080, 16'h0100, 16'h0200, 6'h08);
    wait_done("t3", 200, cyc);
    check("t3_job_cycles_ok", (cyc + 1) <= (32 + SM_LAT + 4), 1'b1);
    tick(1);
    check_rows("t3", 32, 10'h010, 10'h080);
    check("t3_back_to_back", (rd_cyc_log.size() == 32) ? rd_cyc_log[31] - rd_cyc_log[0] : -1, 31);
    check("t3_first_in_lat", (rd_cyc_log.size() > 0) ? first_in_cyc - rd_cyc_log[0] : -1, 2);

    // T4: random sm_in_ready, wr_ready low for 5 cycles mid-job
    clear_logs();
    rand_in = 1'b1;
    start_job(16, 10'h040, 10'h100, 16'h0F0F, 16'hF0F0, 6'h03);
    tick(6);
    wr_ready = 1'b0;
    tick(5);
    wr_ready = 1'b1;
    wait_done("t4", 400, cyc);
    rand_in = 1'b0;
    tick(1);
    check_rows("t4", 16, 10'h040, 10'h100);
    check("t4_in_stable", stall_viol, 0);
    check("t4_no_write_when_blocked", wr_viol, 0);
    check("t4_done_count", done_cnt, 1);

    // T5a: zero-row job
    clear_logs();
    start_job(0, 10'h011, 10'h022, 16'h0001, 16'h0002, 6'h01);
    check("t5a_done_next_cycle", done, 1'b1);
    tick(1);
    check("t5a_done_len", done, 1'b0);
    check("t5a_busy", busy, 1'b0);
    check("t5a_no_reads", rd_log.size(), 0);
    check("t5a_no_writes", wr_data_log.size(), 0);

    // T5b: address wrap on both sides
    clear_logs();
    start_job(4, 10'h3FE, 10'h3FF, 16'h0003, 16'h0004, 6'h02);
    wait_done("t5b", 100, cyc);
    tick(1);
    check_rows("t5b", 4, 10'h3FE, 10'h3FF);

    // T5c: start while busy is ignored
    clear_logs();
    start_job(4, 10'h020, 10'h040, 16'hCAFE, 16'hBEEF, 6'h11);
    tick(1);
    cfg_num_rows = 8'd9; cfg_rd_base = 10'h300; cfg_wr_base = 10'h301;
    cfg_in_scale = 16'h9999; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("t5c", 100, cyc);
    tick(2);
    check_rows("t5c", 4, 10'h020, 10'h040);
    check("t5c_scale_kept", sm_in_scale, 16'hCAFE);
    check("t5c_done_count", done_cnt, 1);
    check("t5c_idle", busy, 1'b0);

    // T6: abort after 10 rows, then a clean 4-row job
    clear_logs();
    start_job(32, 10'h100, 10'h000, 16'h7777, 16'h8888, 6'h07);
    cyc = 0;
    while (wr_data_log.size() < 10 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("t6_reached_10", wr_data_log.size() >= 10, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_idle", busy, 1'b0);
    check("t6_fifo_empty", sm_in_valid, 1'b0);
    check("t6_shift_cleared", sm_shift, '0);
    tick(5);
    check("t6_no_done", done_cnt, 0);
    check("t6_still_idle", busy, 1'b0);
    clear_logs();
    start_job(4, 10'h200, 10'h300, 16'h4444, 16'h5555, 6'h05);
    wait_done("t6b", 100, cyc);
    tick(1);
    check_rows("t6b", 4, 10'h200, 10'h300);
    check("t6b_done_count", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
